// File: rtl/ifmap_pkg.sv
// Shared types and default widths for the IFmap row-writer path.
package ifmap_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 16;
    localparam int unsigned DEF_ADDR_WIDTH     = 4;
    localparam int unsigned DEF_ROW_ADDR_WIDTH = 3;

    function automatic int unsigned depth_of(input int unsigned width);
        return 32'd1 << width;
    endfunction

    localparam int unsigned DEF_DEPTH   = depth_of(DEF_ADDR_WIDTH);
    localparam int unsigned DEF_ROW_CAP = depth_of(DEF_ROW_ADDR_WIDTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        ERR_HOLD = 2'd2
    } fill_state_t;

endpackage

// File: rtl/ifmap_row_tracker.sv
// FIFO of committed row end addresses; the head entry bounds the next release.
module ifmap_row_tracker
    import ifmap_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned ROW_ADDR_WIDTH = DEF_ROW_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [ADDR_WIDTH-1:0]     push_end,
    input  logic                      pop,
    output logic [ROW_ADDR_WIDTH-1:0] wr_slot,
    output logic [ROW_ADDR_WIDTH:0]   count_c,
    output logic [ADDR_WIDTH-1:0]     oldest_end_c
);

    localparam int unsigned ROW_CAP = depth_of(ROW_ADDR_WIDTH);
    localparam int unsigned CW      = ROW_ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] end_mem [ROW_CAP];
    logic [CW-1:0]         row_wptr;
    logic [CW-1:0]         row_rptr;

    // Callers guarantee push only below capacity and pop only when non-empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_wptr <= '0;
            row_rptr <= '0;
            for (int i = 0; i < int'(ROW_CAP); i++) begin
                end_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                end_mem[row_wptr[ROW_ADDR_WIDTH-1:0]] <= push_end;
                row_wptr <= row_wptr + CW'(1);
            end
            if (pop) begin
                row_rptr <= row_rptr + CW'(1);
            end
        end
    end

    assign wr_slot      = row_wptr[ROW_ADDR_WIDTH-1:0];
    assign count_c      = row_wptr - row_rptr;
    assign oldest_end_c = end_mem[row_rptr[ROW_ADDR_WIDTH-1:0]];

endmodule

// File: rtl/ifmap_row_writer.sv
// Streams IFmap words into the circular scratchpad and publishes completed rows.
// Optional build macro ROW_LEN_CHECK_EN adds the sticky len_err row-length check.
module ifmap_row_writer
    import ifmap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned ROW_ADDR_WIDTH = DEF_ROW_ADDR_WIDTH,
    parameter int unsigned ROW_LEN        = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic                      buf_wen,
    output logic [ADDR_WIDTH-1:0]     buf_waddr,
    output logic [DATA_WIDTH-1:0]     buf_wdata,
    output logic                      row_wen,
    output logic [ROW_ADDR_WIDTH-1:0] row_waddr,
    output logic [ADDR_WIDTH-1:0]     row_start,
    output logic [ADDR_WIDTH-1:0]     row_end,
    input  logic                      row_release,
    output logic [ROW_ADDR_WIDTH:0]   rows_avail,
    output logic                      buf_full,
`ifdef ROW_LEN_CHECK_EN
    output logic                      len_err,
`endif
    output logic                      err
);

    localparam int unsigned DEPTH   = depth_of(ADDR_WIDTH);
    localparam int unsigned ROW_CAP = depth_of(ROW_ADDR_WIDTH);
    localparam int unsigned PW      = ADDR_WIDTH + 1;
    localparam int unsigned RW      = ROW_ADDR_WIDTH + 1;

    fill_state_t               state;
    fill_state_t               state_next;
    logic                      run;
    logic [PW-1:0]             wptr;
    logic [PW-1:0]             tail;
    logic [PW-1:0]             used;
    logic [PW-1:0]             rel_len;
    logic [ADDR_WIDTH-1:0]     row_head;
    logic [ADDR_WIDTH-1:0]     oldest_end;
    logic [ROW_ADDR_WIDTH-1:0] wr_slot;
    logic                      accept;
    logic                      commit;
    logic                      first_word;
    logic                      overflow;
    logic                      release_ok;
    logic                      bad_release;

    assign used     = wptr - tail;
    assign buf_full = (used == PW'(DEPTH));

    // Oldest row always starts at tail, so its length follows from its end address.
    assign rel_len     = PW'(ADDR_WIDTH'(oldest_end - tail[ADDR_WIDTH-1:0])) + PW'(1);
    assign release_ok  = row_release && (rows_avail != '0);
    assign bad_release = row_release && (rows_avail == '0);

    ifmap_row_tracker #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .ROW_ADDR_WIDTH (ROW_ADDR_WIDTH)
    ) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .push         (commit),
        .push_end     (wptr[ADDR_WIDTH-1:0]),
        .pop          (release_ok),
        .wr_slot      (wr_slot),
        .count_c      (rows_avail),
        .oldest_end_c (oldest_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (accept && !in_last) state_next = FILL;
            FILL: begin
                if (accept && in_last) begin
                    state_next = IDLE;
                end else if (overflow) begin
                    state_next = ERR_HOLD;
                end
            end
            ERR_HOLD: state_next = ERR_HOLD;
            default:  state_next = IDLE;
        endcase
    end

    // run keeps in_ready low while reset is held and for the first edge after it.
    always_comb begin
        in_ready   = run && !buf_full && (rows_avail < RW'(ROW_CAP)) && (state != ERR_HOLD);
        accept     = in_valid && in_ready;
        commit     = accept && in_last;
        first_word = (state == IDLE);
        overflow   = (state == FILL) && buf_full && (rows_avail == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run       <= 1'b0;
            wptr      <= '0;
            tail      <= '0;
            row_head  <= '0;
            buf_wen   <= 1'b0;
            buf_waddr <= '0;
            buf_wdata <= '0;
            row_wen   <= 1'b0;
            row_waddr <= '0;
            row_start <= '0;
            row_end   <= '0;
            err       <= 1'b0;
        end else begin
            run     <= 1'b1;
            buf_wen <= accept;
            row_wen <= commit;
            if (accept) begin
                buf_waddr <= wptr[ADDR_WIDTH-1:0];
                buf_wdata <= in_data;
                wptr      <= wptr + PW'(1);
                if (first_word) begin
                    row_head <= wptr[ADDR_WIDTH-1:0];
                end
            end
            if (commit) begin
                row_waddr <= wr_slot;
                row_start <= first_word ? wptr[ADDR_WIDTH-1:0] : row_head;
                row_end   <= wptr[ADDR_WIDTH-1:0];
            end
            if (release_ok) begin
                tail <= tail + rel_len;
            end
            if (bad_release || overflow) begin
                err <= 1'b1;
            end
        end
    end

`ifdef ROW_LEN_CHECK_EN
    logic [PW-1:0] word_cnt;
    logic [PW-1:0] cnt_next;

    assign cnt_next = first_word ? PW'(1) : word_cnt + PW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= '0;
            len_err  <= 1'b0;
        end else if (accept) begin
            word_cnt <= cnt_next;
            if (in_last && (cnt_next != PW'(ROW_LEN))) begin
                len_err <= 1'b1;
            end
        end
    end
`else
    if (ROW_LEN == 0) begin : g_row_len_check
        $error("ROW_LEN must be nonzero");
    end
`endif

endmodule

// File: tb/tb_ifmap_row_writer.sv
// Directed bench for ifmap_row_writer; define ROW_LEN_CHECK_EN to also cover len_err.
module tb_ifmap_row_writer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        buf_wen;
    logic [3:0]  buf_waddr;
    logic [15:0] buf_wdata;
    logic        row_wen;
    logic [2:0]  row_waddr;
    logic [3:0]  row_start;
    logic [3:0]  row_end;
    logic        row_release;
    logic [3:0]  rows_avail;
    logic        buf_full;
    logic        err;
`ifdef ROW_LEN_CHECK_EN
    logic        len_err;
`endif

    int vectors;
    int miscompares;

    ifmap_row_writer #(
        .DATA_WIDTH     (16),
        .ADDR_WIDTH     (4),
        .ROW_ADDR_WIDTH (3),
        .ROW_LEN        (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .buf_wen     (buf_wen),
        .buf_waddr   (buf_waddr),
        .buf_wdata   (buf_wdata),
        .row_wen     (row_wen),
        .row_waddr   (row_waddr),
        .row_start   (row_start),
        .row_end     (row_end),
        .row_release (row_release),
        .rows_avail  (rows_avail),
        .buf_full    (buf_full),
`ifdef ROW_LEN_CHECK_EN
        .len_err     (len_err),
`endif
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; results of the next rising edge are read one falling edge later.
    task automatic beat(input logic v, input logic [15:0] d, input logic l, input logic r);
        in_valid    = v;
        in_data     = d;
        in_last     = l;
        row_release = r;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; row_release = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; row_release = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, buf_wen, buf_waddr, buf_wdata, row_wen, row_waddr, row_start, row_end,
             rows_avail, buf_full, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: in_ready=%b buf_wen=%b rows_avail=%0d buf_full=%b err=%b want all 0",
                     in_ready, buf_wen, rows_avail, buf_full, err);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_single_row();
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 16'(16'hA0 + i), i == 3, 1'b0);
            vectors++;
            if (buf_wen !== 1'b1 || buf_waddr !== 4'(i) || buf_wdata !== 16'(16'hA0 + i)
                || row_wen !== (i == 3)) begin
                miscompares++;
                $display("FAIL single_write[%0d]: wen=%b addr=%0d data=%h row_wen=%b want 1 %0d %h %b",
                         i, buf_wen, buf_waddr, buf_wdata, row_wen, i, 16'(16'hA0 + i), i == 3);
            end
        end
        vectors++;
        if (row_waddr !== 3'd0 || row_start !== 4'd0 || row_end !== 4'd3 || rows_avail !== 4'd1) begin
            miscompares++;
            $display("FAIL single_commit: slot=%0d start=%0d end=%0d avail=%0d want 0 0 3 1",
                     row_waddr, row_start, row_end, rows_avail);
        end
        beat(1'b0, '0, 1'b0, 1'b0);
        vectors++;
        if (buf_wen !== 1'b0 || row_wen !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: buf_wen=%b row_wen=%b want 0 0", buf_wen, row_wen);
        end
    endtask

    task automatic test_full_backpressure();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            beat(1'b1, 16'(16'h10 + i), (i == 7) || (i == 15), 1'b0);
            vectors++;
            if (buf_wen !== 1'b1 || buf_waddr !== 4'(i)) begin
                miscompares++;
                $display("FAIL full_write[%0d]: wen=%b addr=%0d want 1 %0d", i, buf_wen, buf_waddr, i);
            end
        end
        vectors++;
        if (row_wen !== 1'b1 || row_waddr !== 3'd1 || row_start !== 4'd8 || row_end !== 4'd15
            || rows_avail !== 4'd2 || buf_full !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_state: row_wen=%b slot=%0d start=%0d end=%0d avail=%0d full=%b ready=%b want 1 1 8 15 2 1 0",
                     row_wen, row_waddr, row_start, row_end, rows_avail, buf_full, in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            beat(1'b1, 16'hC0, 1'b1, 1'b0);
            vectors++;
            if (buf_wen !== 1'b0) begin
                miscompares++;
                $display("FAIL full_stall[%0d]: buf_wen=%b want 0", i, buf_wen);
            end
        end
        beat(1'b1, 16'hC0, 1'b1, 1'b1);
        vectors++;
        if (in_ready !== 1'b1 || buf_wen !== 1'b0 || rows_avail !== 4'd1 || buf_full !== 1'b0) begin
            miscompares++;
            $display("FAIL full_release: ready=%b wen=%b avail=%0d full=%b want 1 0 1 0",
                     in_ready, buf_wen, rows_avail, buf_full);
        end
        beat(1'b1, 16'hC0, 1'b1, 1'b0);
        vectors++;
        if (buf_wen !== 1'b1 || buf_waddr !== 4'd0 || row_wen !== 1'b1 || row_waddr !== 3'd2
            || row_start !== 4'd0 || row_end !== 4'd0 || rows_avail !== 4'd2) begin
            miscompares++;
            $display("FAIL full_row3: wen=%b addr=%0d row_wen=%b slot=%0d start=%0d end=%0d avail=%0d want 1 0 1 2 0 0 2",
                     buf_wen, buf_waddr, row_wen, row_waddr, row_start, row_end, rows_avail);
        end
    endtask

    task automatic test_wrap();
        beat(1'b0, '0, 1'b0, 1'b1);
        beat(1'b0, '0, 1'b0, 1'b1);
        vectors++;
        if (rows_avail !== 4'd0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_drain: avail=%0d err=%b want 0 0", rows_avail, err);
        end
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, 16'(16'hD0 + i), i == 9, 1'b0);
            vectors++;
            if (buf_wen !== 1'b1 || buf_waddr !== 4'(1 + i)) begin
                miscompares++;
                $display("FAIL wrap_write[%0d]: wen=%b addr=%0d want 1 %0d", i, buf_wen, buf_waddr, 1 + i);
            end
        end
        vectors++;
        if (row_wen !== 1'b1 || row_waddr !== 3'd3 || row_start !== 4'd1 || row_end !== 4'd10) begin
            miscompares++;
            $display("FAIL wrap_row10: row_wen=%b slot=%0d start=%0d end=%0d want 1 3 1 10",
                     row_wen, row_waddr, row_start, row_end);
        end
        beat(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            beat(1'b1, 16'(16'hE0 + i), i == 6, 1'b0);
            vectors++;
            if (buf_wen !== 1'b1 || buf_waddr !== 4'(11 + i)) begin
                miscompares++;
                $display("FAIL wrap_span[%0d]: wen=%b addr=%0d want 1 %0d", i, buf_wen, buf_waddr, 4'(11 + i));
            end
        end
        vectors++;
        if (row_wen !== 1'b1 || row_waddr !== 3'd4 || row_start !== 4'd11 || row_end !== 4'd1
            || rows_avail !== 4'd1) begin
            miscompares++;
            $display("FAIL wrap_end_lt_start: row_wen=%b slot=%0d start=%0d end=%0d avail=%0d want 1 4 11 1 1",
                     row_wen, row_waddr, row_start, row_end, rows_avail);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 16'(16'hF0 + i), i == 2, i == 2);
        end
        vectors++;
        if (row_wen !== 1'b1 || row_waddr !== 3'd5 || row_start !== 4'd2 || row_end !== 4'd4
            || rows_avail !== 4'd1) begin
            miscompares++;
            $display("FAIL sim_commit_release: row_wen=%b slot=%0d start=%0d end=%0d avail=%0d want 1 5 2 4 1",
                     row_wen, row_waddr, row_start, row_end, rows_avail);
        end
        // Exactly 13 free words remain only if the release freed all 7 words of the wrapped row.
        for (int i = 0; i < 13; i++) begin
            beat(1'b1, 16'(16'h100 + i), i == 12, 1'b0);
            vectors++;
            if (buf_wen !== 1'b1 || buf_waddr !== 4'(5 + i)) begin
                miscompares++;
                $display("FAIL sim_fill[%0d]: wen=%b addr=%0d want 1 %0d", i, buf_wen, buf_waddr, 4'(5 + i));
            end
        end
        vectors++;
        if (row_start !== 4'd5 || row_end !== 4'd1 || row_waddr !== 3'd6 || buf_full !== 1'b1
            || in_ready !== 1'b0 || rows_avail !== 4'd2) begin
            miscompares++;
            $display("FAIL sim_full: start=%0d end=%0d slot=%0d full=%b ready=%b avail=%0d want 5 1 6 1 0 2",
                     row_start, row_end, row_waddr, buf_full, in_ready, rows_avail);
        end
        beat(1'b0, '0, 1'b0, 1'b1);
        beat(1'b0, '0, 1'b0, 1'b1);
        vectors++;
        if (rows_avail !== 4'd0 || err !== 1'b0 || in_ready !== 1'b1 || buf_full !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_drain: avail=%0d err=%b ready=%b full=%b want 0 0 1 0",
                     rows_avail, err, in_ready, buf_full);
        end
        beat(1'b0, '0, 1'b0, 1'b1);
        beat(1'b0, '0, 1'b0, 1'b0);
        vectors++;
        if (err !== 1'b1 || rows_avail !== 4'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_release: err=%b avail=%0d ready=%b want 1 0 1", err, rows_avail, in_ready);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            beat(1'b1, 16'(16'h200 + i), 1'b0, 1'b0);
        end
        vectors++;
        if (buf_full !== 1'b1 || in_ready !== 1'b0 || err !== 1'b0 || buf_waddr !== 4'd15) begin
            miscompares++;
            $display("FAIL ovf_full: full=%b ready=%b err=%b addr=%0d want 1 0 0 15",
                     buf_full, in_ready, err, buf_waddr);
        end
        beat(1'b0, '0, 1'b0, 1'b0);
        beat(1'b1, 16'h2FF, 1'b1, 1'b1);
        vectors++;
        if (err !== 1'b1 || in_ready !== 1'b0 || buf_wen !== 1'b0 || row_wen !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_hold: err=%b ready=%b wen=%b row_wen=%b want 1 0 0 0",
                     err, in_ready, buf_wen, row_wen);
        end
    endtask

    task automatic test_reset_mid_row();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 16'(16'h300 + i), 1'b0, 1'b0);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({in_ready, buf_wen, buf_waddr, buf_wdata, row_wen, row_waddr, row_start, row_end,
             rows_avail, buf_full, err} !== '0) begin
            miscompares++;
            $display("FAIL midrow_reset: ready=%b wen=%b addr=%0d data=%h avail=%0d want all 0",
                     in_ready, buf_wen, buf_waddr, buf_wdata, rows_avail);
        end
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        beat(1'b1, 16'h310, 1'b0, 1'b0);
        vectors++;
        if (buf_wen !== 1'b1 || buf_waddr !== 4'd0 || buf_wdata !== 16'h310) begin
            miscompares++;
            $display("FAIL midrow_restart: wen=%b addr=%0d data=%h want 1 0 0310", buf_wen, buf_waddr, buf_wdata);
        end
        beat(1'b1, 16'h311, 1'b1, 1'b0);
        vectors++;
        if (row_wen !== 1'b1 || row_waddr !== 3'd0 || row_start !== 4'd0 || row_end !== 4'd1) begin
            miscompares++;
            $display("FAIL midrow_commit: row_wen=%b slot=%0d start=%0d end=%0d want 1 0 0 1",
                     row_wen, row_waddr, row_start, row_end);
        end
        beat(1'b0, '0, 1'b0, 1'b0);
    endtask

`ifdef ROW_LEN_CHECK_EN
    task automatic test_len_check();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 16'(16'h400 + i), i == 7, 1'b0);
        end
        vectors++;
        if (len_err !== 1'b0 || row_wen !== 1'b1) begin
            miscompares++;
            $display("FAIL len_ok: len_err=%b row_wen=%b want 0 1", len_err, row_wen);
        end
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            beat(1'b1, 16'(16'h500 + i), i == 6, 1'b0);
        end
        vectors++;
        if (len_err !== 1'b1 || row_wen !== 1'b1 || row_start !== 4'd0 || row_end !== 4'd6) begin
            miscompares++;
            $display("FAIL len_short: len_err=%b row_wen=%b start=%0d end=%0d want 1 1 0 6",
                     len_err, row_wen, row_start, row_end);
        end
        beat(1'b0, '0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_row();
        test_full_backpressure();
        test_wrap();
        test_simultaneous();
        test_overflow();
        test_reset_mid_row();
`ifdef ROW_LEN_CHECK_EN
        test_len_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
